// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants: FSM state encoding, the
// {pc, instr} entry that travels from fetch to decode, and PC alignment.
package riscv_pkg;

   localparam int          INSTR_W = 32;
   localparam int          XLEN    = 32;
   localparam logic [31:0] PC_STEP = 32'd4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   // Instructions are word aligned; the low two address bits are dropped.
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
      return {pc[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small shift-register FIFO of fetch entries feeding decode.
// Entry 0 is always the head, so the presented data comes straight from
// flops. Push and pop may happen in the same cycle, including when full.
// A synchronous flush empties the FIFO (stale data may remain in the
// entries but is never marked valid).
module fetch_buffer
   import riscv_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  fetch_entry_t     push_data,
   input  logic             pop,
   output logic             head_valid,
   output fetch_entry_t     head_data,
   output logic [CNT_W-1:0] count
);

   fetch_entry_t     mem_r [DEPTH];
   logic [CNT_W-1:0] count_r;
   logic             pop_ok_s;
   logic             push_ok_s;
   logic [CNT_W-1:0] wr_idx_s;

   // Qualify push/pop against occupancy and locate the write slot after any shift.
   always_comb begin
      pop_ok_s  = pop && (count_r != {CNT_W{1'b0}});
      push_ok_s = push && ((count_r != CNT_W'(DEPTH)) || pop_ok_s);
      if (pop_ok_s) begin
         wr_idx_s = count_r - CNT_W'(1);
      end else begin
         wr_idx_s = count_r;
      end
   end

   // Storage update: shift toward the head on pop, write the new entry behind the last valid one.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_r <= {CNT_W{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (flush) begin
         count_r <= {CNT_W{1'b0}};
      end else begin
         count_r <= count_r + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
         for (int i = 0; i < DEPTH - 1; i++) begin
            if (push_ok_s && (wr_idx_s == CNT_W'(i))) begin
               mem_r[i] <= push_data;
            end else if (pop_ok_s) begin
               mem_r[i] <= mem_r[i+1];
            end else begin
               mem_r[i] <= mem_r[i];
            end
         end
         if (push_ok_s && (wr_idx_s == CNT_W'(DEPTH - 1))) begin
            mem_r[DEPTH-1] <= push_data;
         end
      end
   end

   assign head_valid = (count_r != {CNT_W{1'b0}});
   assign head_data  = mem_r[0];
   assign count      = count_r;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, issues one outstanding
// req/gnt/rvalid fetch at a time, buffers returned words for decode and
// handles halt, backpressure and redirects (discarding in-flight fetches
// that a redirect made obsolete).
// Optional build macro FETCH_TRACE_EN: prints each decode handshake and
// each redirect; behaviour is otherwise identical.
module fetch_ctrl
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [31:0] id_instr,
   input  logic        id_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt_req
);

   localparam int CNT_W = $clog2(BUF_DEPTH + 1);
   localparam int OCC_W = 4;

   fetch_state_t     state_r;
   logic [31:0]      fetch_pc_r;
   logic [31:0]      imem_addr_r;
   logic [31:0]      inflight_pc_r;
   logic             drop_r;
   logic             redir_pend_r;

   logic [31:0]      redir_pc_s;
   logic [31:0]      fetch_pc_next_s;
   logic             resp_s;
   logic             push_s;
   logic             pop_s;
   logic             flush_s;
   logic [OCC_W-1:0] occ_next_s;
   logic             credit_ok_s;
   fetch_entry_t     push_data_s;
   logic             head_valid_s;
   fetch_entry_t     head_data_s;
   logic [CNT_W-1:0] count_s;

   // Buffer control, next fetch PC and the credit check on post-update occupancy.
   always_comb begin
      redir_pc_s        = align_pc(redirect_pc);
      resp_s            = (state_r == WAIT) && imem_rvalid;
      flush_s           = redirect_valid;
      push_s            = resp_s && !drop_r && !redirect_valid;
      pop_s             = head_valid_s && !redirect_valid && id_ready;
      push_data_s.pc    = inflight_pc_r;
      push_data_s.instr = imem_rdata;
      if (flush_s) begin
         occ_next_s = {OCC_W{1'b0}};
      end else begin
         occ_next_s = OCC_W'(count_s) + OCC_W'(push_s) - OCC_W'(pop_s);
      end
      credit_ok_s = !halt_req && (occ_next_s < OCC_W'(BUF_DEPTH));
      // A redirect seen while a request was waiting for gnt keeps its target in fetch_pc_r.
      if (redirect_valid) begin
         fetch_pc_next_s = redir_pc_s;
      end else if ((state_r == REQ) && imem_gnt && !redir_pend_r) begin
         fetch_pc_next_s = imem_addr_r + PC_STEP;
      end else begin
         fetch_pc_next_s = fetch_pc_r;
      end
   end

   // Fetch FSM with PC, address, in-flight tracking and drop bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= IDLE;
         fetch_pc_r    <= RESET_PC;
         imem_addr_r   <= RESET_PC;
         inflight_pc_r <= 32'h0000_0000;
         drop_r        <= 1'b0;
         redir_pend_r  <= 1'b0;
      end else begin
         fetch_pc_r <= fetch_pc_next_s;
         case (state_r)
            IDLE: begin
               imem_addr_r <= fetch_pc_next_s;
               if (credit_ok_s) begin
                  state_r <= REQ;
               end else begin
                  state_r <= IDLE;
               end
            end
            REQ: begin
               if (imem_gnt) begin
                  inflight_pc_r <= imem_addr_r;
                  imem_addr_r   <= fetch_pc_next_s;
                  drop_r        <= redirect_valid || redir_pend_r;
                  redir_pend_r  <= 1'b0;
                  state_r       <= WAIT;
               end else begin
                  redir_pend_r  <= redir_pend_r || redirect_valid;
                  state_r       <= REQ;
               end
            end
            WAIT: begin
               imem_addr_r <= fetch_pc_next_s;
               if (redirect_valid) begin
                  drop_r <= 1'b1;
               end else if (imem_rvalid) begin
                  drop_r <= 1'b0;
               end else begin
                  drop_r <= drop_r;
               end
               if (imem_rvalid) begin
                  if (credit_ok_s) begin
                     state_r <= REQ;
                  end else begin
                     state_r <= IDLE;
                  end
               end else begin
                  state_r <= WAIT;
               end
            end
            default: begin
               state_r      <= IDLE;
               drop_r       <= 1'b0;
               redir_pend_r <= 1'b0;
            end
         endcase
      end
   end

   fetch_buffer #(
      .DEPTH (BUF_DEPTH)
   ) u_fetch_buffer (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush_s),
      .push       (push_s),
      .push_data  (push_data_s),
      .pop        (pop_s),
      .head_valid (head_valid_s),
      .head_data  (head_data_s),
      .count      (count_s)
   );

   assign imem_req  = (state_r == REQ);
   assign imem_addr = imem_addr_r;
   assign id_valid  = head_valid_s && !redirect_valid;
   assign id_pc     = head_data_s.pc;
   assign id_instr  = head_data_s.instr;

`ifdef FETCH_TRACE_EN
   // Trace decode handshakes and redirects.
   always @(posedge clk) begin
      if (!reset && pop_s) begin
         $display("pc=0x%h, instr=0x%h (fetch)", head_data_s.pc, head_data_s.instr);
      end
      if (!reset && redirect_valid) begin
         $display("redirect -> 0x%h", redir_pc_s);
      end
   end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a behavioural instruction memory with
// programmable response latency, handshake/grant logs and hand-computed
// expectations for each scenario.
module tb_fetch_ctrl;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic        id_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt_req;

   int          n_checks;
   int          n_fail;
   int          lat;
   logic        pend;
   int          cd;
   logic [31:0] paddr;
   logic [31:0] hs_pc [64];
   logic [31:0] hs_in [64];
   logic [31:0] gr_addr [64];
   int          hs_n;
   int          gr_n;

   fetch_ctrl #(
      .RESET_PC  (32'h0000_0000),
      .BUF_DEPTH (2)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .id_valid       (id_valid),
      .id_pc          (id_pc),
      .id_instr       (id_instr),
      .id_ready       (id_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt_req       (halt_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h0050_0093;
         32'h0000_0004: return 32'h00A0_0113;
         default:       return a ^ 32'h1357_9BDF;
      endcase
   endfunction

   function automatic logic [31:0] hs_pc_at(input int i);
      return (i < hs_n && i < 64) ? hs_pc[i] : 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] hs_in_at(input int i);
      return (i < hs_n && i < 64) ? hs_in[i] : 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] gr_at(input int i);
      return (i < gr_n && i < 64) ? gr_addr[i] : 32'hDEAD_BEEF;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance n clocks and settle 2 time units after the rising edge.
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      redirect_valid = 1'b0;
      cyc(3);
      reset = 1'b0;
      hs_n = 0;
      gr_n = 0;
   endtask

   // Memory responder: a grant seen mid-cycle returns data lat cycles later.
   initial begin
      pend = 1'b0;
      cd = 0;
      paddr = 32'h0;
      forever begin
         @(negedge clk);
         if (imem_req === 1'b1 && imem_gnt === 1'b1) begin
            pend = 1'b1;
            cd = lat;
            paddr = imem_addr;
         end
         @(posedge clk);
         #1;
         imem_rvalid = 1'b0;
         if (pend) begin
            cd = cd - 1;
            if (cd <= 0) begin
               imem_rvalid = 1'b1;
               imem_rdata = mem_word(paddr);
               pend = 1'b0;
            end
         end
      end
   end

   // Logs of decode handshakes and memory grants, sampled mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (id_valid === 1'b1 && id_ready === 1'b1) begin
            if (hs_n < 64) begin
               hs_pc[hs_n] = id_pc;
               hs_in[hs_n] = id_instr;
            end
            hs_n++;
         end
         if (imem_req === 1'b1 && imem_gnt === 1'b1) begin
            if (gr_n < 64) gr_addr[gr_n] = imem_addr;
            gr_n++;
         end
      end
   end

   initial begin
      n_checks = 0;
      n_fail = 0;
      hs_n = 0;
      gr_n = 0;
      lat = 1;
      reset = 1'b1;
      imem_gnt = 1'b1;
      imem_rvalid = 1'b0;
      imem_rdata = 32'h0;
      id_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;
      halt_req = 1'b0;

      // 1: reset values, first fetches, latency and throughput
      cyc(3);
      check_eq("rst_req", imem_req, 32'd0);
      check_eq("rst_addr", imem_addr, 32'h0);
      check_eq("rst_valid", id_valid, 32'd0);
      check_eq("rst_pc", id_pc, 32'h0);
      check_eq("rst_instr", id_instr, 32'h0);
      reset = 1'b0;
      hs_n = 0;
      gr_n = 0;
      cyc(1);
      check_eq("t1_c1_req", imem_req, 32'd1);
      check_eq("t1_c1_addr", imem_addr, 32'h0);
      cyc(1);
      check_eq("t1_c2_req", imem_req, 32'd0);
      check_eq("t1_c2_valid", id_valid, 32'd0);
      cyc(1);
      check_eq("t1_c3_valid", id_valid, 32'd1);
      check_eq("t1_c3_pc", id_pc, 32'h0);
      check_eq("t1_c3_instr", id_instr, 32'h0050_0093);
      check_eq("t1_c3_addr", imem_addr, 32'h4);
      cyc(1);
      check_eq("t1_c4_valid", id_valid, 32'd0);
      cyc(1);
      check_eq("t1_c5_valid", id_valid, 32'd1);
      check_eq("t1_c5_pc", id_pc, 32'h4);
      check_eq("t1_c5_instr", id_instr, 32'h00A0_0113);
      check_eq("t1_c5_addr", imem_addr, 32'h8);

      // 2: decode stalled; credit limits to two grants, then drain in order
      id_ready = 1'b0;
      do_reset();
      cyc(12);
      check_eq("t2_grants", gr_n, 32'd2);
      check_eq("t2_gr0", gr_at(0), 32'h0);
      check_eq("t2_gr1", gr_at(1), 32'h4);
      check_eq("t2_req", imem_req, 32'd0);
      check_eq("t2_valid", id_valid, 32'd1);
      check_eq("t2_pc", id_pc, 32'h0);
      id_ready = 1'b1;
      cyc(10);
      check_eq("t2_hs0", hs_pc_at(0), 32'h0);
      check_eq("t2_hs1", hs_pc_at(1), 32'h4);
      check_eq("t2_hs2", hs_pc_at(2), 32'h8);
      check_eq("t2_hs2_instr", hs_in_at(2), 32'h1357_9BD7);

      // 2b: redirect while full and idle gates id_valid and flushes
      id_ready = 1'b0;
      do_reset();
      cyc(10);
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0042;
      id_ready = 1'b1;
      hs_n = 0;
      gr_n = 0;
      #1;
      check_eq("t2b_gate", id_valid, 32'd0);
      cyc(1);
      redirect_valid = 1'b0;
      id_ready = 1'b0;
      check_eq("t2b_flushed", id_valid, 32'd0);
      check_eq("t2b_req", imem_req, 32'd1);
      check_eq("t2b_addr", imem_addr, 32'h40);
      cyc(10);
      check_eq("t2b_no_hs", hs_n, 32'd0);
      check_eq("t2b_pc", id_pc, 32'h40);
      check_eq("t2b_instr", id_instr, 32'h1357_9B9F);
      check_eq("t2b_grants", gr_n, 32'd2);
      check_eq("t2b_gr1", gr_at(1), 32'h44);

      // 3: redirect while waiting for the 0x8 response
      id_ready = 1'b1;
      lat = 2;
      do_reset();
      for (int i = 0; i < 40; i++) begin
         if (imem_req === 1'b1 && imem_addr === 32'h8) break;
         cyc(1);
      end
      check_eq("t3_reach8", imem_addr, 32'h8);
      cyc(1);
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0100;
      #1;
      check_eq("t3_wait_req", imem_req, 32'd0);
      cyc(1);
      redirect_valid = 1'b0;
      hs_n = 0;
      gr_n = 0;
      cyc(1);
      check_eq("t3_req", imem_req, 32'd1);
      check_eq("t3_addr", imem_addr, 32'h100);
      cyc(6);
      check_eq("t3_hs0_pc", hs_pc_at(0), 32'h100);
      check_eq("t3_hs0_instr", hs_in_at(0), 32'h1357_9ADF);
      check_eq("t3_gr0", gr_at(0), 32'h100);

      // 4: redirect while the request waits for gnt
      lat = 1;
      imem_gnt = 1'b0;
      do_reset();
      cyc(1);
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0203;
      #1;
      check_eq("t4_c1_req", imem_req, 32'd1);
      check_eq("t4_c1_addr", imem_addr, 32'h0);
      cyc(1);
      redirect_valid = 1'b0;
      check_eq("t4_c2_addr", imem_addr, 32'h0);
      cyc(1);
      check_eq("t4_c3_addr", imem_addr, 32'h0);
      cyc(1);
      imem_gnt = 1'b1;
      check_eq("t4_c4_req", imem_req, 32'd1);
      check_eq("t4_c4_addr", imem_addr, 32'h0);
      cyc(1);
      check_eq("t4_c5_req", imem_req, 32'd0);
      cyc(1);
      check_eq("t4_c6_req", imem_req, 32'd1);
      check_eq("t4_c6_addr", imem_addr, 32'h200);
      cyc(6);
      check_eq("t4_hs0_pc", hs_pc_at(0), 32'h200);
      check_eq("t4_hs0_instr", hs_in_at(0), 32'h1357_99DF);
      check_eq("t4_hs1_pc", hs_pc_at(1), 32'h204);

      // 5: halt holds off fetch; redirect to the top word wraps to zero
      halt_req = 1'b1;
      do_reset();
      cyc(2);
      check_eq("t5_halt_req", imem_req, 32'd0);
      cyc(1);
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      cyc(1);
      redirect_valid = 1'b0;
      halt_req = 1'b0;
      hs_n = 0;
      gr_n = 0;
      cyc(8);
      check_eq("t5_gr0", gr_at(0), 32'hFFFF_FFFC);
      check_eq("t5_gr1", gr_at(1), 32'h0);
      check_eq("t5_hs0_pc", hs_pc_at(0), 32'hFFFF_FFFC);
      check_eq("t5_hs1_pc", hs_pc_at(1), 32'h0);
      check_eq("t5_hs1_instr", hs_in_at(1), 32'h0050_0093);

      // 6: reset during WAIT with a stale response right after
      lat = 2;
      do_reset();
      cyc(1);
      check_eq("t6_c1_req", imem_req, 32'd1);
      check_eq("t6_c1_addr", imem_addr, 32'h0);
      cyc(1);
      reset = 1'b1;
      check_eq("t6_c2_req", imem_req, 32'd0);
      cyc(1);
      reset = 1'b0;
      hs_n = 0;
      #1;
      check_eq("t6_c3_valid", id_valid, 32'd0);
      check_eq("t6_c3_req", imem_req, 32'd0);
      cyc(1);
      check_eq("t6_c4_req", imem_req, 32'd1);
      check_eq("t6_c4_addr", imem_addr, 32'h0);
      cyc(2);
      check_eq("t6_c6_valid", id_valid, 32'd0);
      cyc(4);
      check_eq("t6_hs0_pc", hs_pc_at(0), 32'h0);
      check_eq("t6_hs0_instr", hs_in_at(0), 32'h0050_0093);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
